// File: rtl/ps2_key_token_rx_if.sv
// PS/2 line inputs and calculator token outputs of the key receiver.
// master = line driver / token consumer, slave = the receiver itself.
interface ps2_key_token_rx_if;
  logic       iPS2_CLK;
  logic       iPS2_DAT;
  logic       oKEY_VALID;
  logic [4:0] oKEY_CODE;
  logic [7:0] oSCAN_CODE;
  logic       oPARITY_ERR;
  logic       oFRAME_ERR;

  modport master (
    output iPS2_CLK, iPS2_DAT,
    input  oKEY_VALID, oKEY_CODE, oSCAN_CODE, oPARITY_ERR, oFRAME_ERR
  );

  modport slave (
    input  iPS2_CLK, iPS2_DAT,
    output oKEY_VALID, oKEY_CODE, oSCAN_CODE, oPARITY_ERR, oFRAME_ERR
  );
endinterface

// File: rtl/ps2_key_token_rx.sv
// PS/2 keyboard receiver: deglitch, deserialise 11-bit frames, decode E0/F0 prefixes into 5-bit calculator tokens.
// Token/error pulses appear 2 cycles after the stop-bit strobe; no backpressure, every pulse lasts one cycle.
module ps2_key_token_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              iCLK_50,
  input logic              iRST_n,
  ps2_key_token_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt, filt_prev, strobe;
  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par;
  logic [TW-1:0]         tcnt;
  logic                  byte_ok, par_bad, frm_bad;
  logic                  ext, brk;
  logic                  key_valid, parity_err, frame_err;
  logic [4:0]            key_code;
  logic [7:0]            scan_code;
  logic [5:0]            lut;

  assign strobe          = filt_prev & ~filt;
  assign bus.oKEY_VALID  = key_valid;
  assign bus.oKEY_CODE   = key_code;
  assign bus.oSCAN_CODE  = scan_code;
  assign bus.oPARITY_ERR = parity_err;
  assign bus.oFRAME_ERR  = frame_err;

  // Synchronisers and clock filter; lines idle high so they reset to 1.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_sr   <= '1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_s1    <= bus.iPS2_CLK;
      clk_s2    <= clk_s1;
      dat_s1    <= bus.iPS2_DAT;
      dat_s2    <= dat_s1;
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      filt_prev <= filt;
      if (&filt_sr)
        filt <= 1'b1;
      else if (~|filt_sr)
        filt <= 1'b0;
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
      byte_ok <= 1'b0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
    end else begin
      byte_ok <= 1'b0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          IDLE: if (!dat_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // A bad stop bit takes precedence over the parity verdict.
            if (!dat_s2)
              frm_bad <= 1'b1;
            else if (^{shreg, par})
              byte_ok <= 1'b1;
            else
              par_bad <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TOUT_LAST) begin
          state   <= IDLE;
          frm_bad <= 1'b1;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // {hit, token}; keypad-range codes only map without the E0 prefix.
  always_comb begin
    lut = '0;
    case (shreg)
      8'h45: lut = {1'b1, 5'd0};
      8'h16: lut = {1'b1, 5'd1};
      8'h1E: lut = {1'b1, 5'd2};
      8'h26: lut = {1'b1, 5'd3};
      8'h25: lut = {1'b1, 5'd4};
      8'h2E: lut = {1'b1, 5'd5};
      8'h36: lut = {1'b1, 5'd6};
      8'h3D: lut = {1'b1, 5'd7};
      8'h3E: lut = {1'b1, 5'd8};
      8'h46: lut = {1'b1, 5'd9};
      8'h70: if (!ext) lut = {1'b1, 5'd0};
      8'h69: if (!ext) lut = {1'b1, 5'd1};
      8'h72: if (!ext) lut = {1'b1, 5'd2};
      8'h7A: if (!ext) lut = {1'b1, 5'd3};
      8'h6B: if (!ext) lut = {1'b1, 5'd4};
      8'h73: if (!ext) lut = {1'b1, 5'd5};
      8'h74: if (!ext) lut = {1'b1, 5'd6};
      8'h6C: if (!ext) lut = {1'b1, 5'd7};
      8'h75: if (!ext) lut = {1'b1, 5'd8};
      8'h7D: if (!ext) lut = {1'b1, 5'd9};
      8'h79: if (!ext) lut = {1'b1, 5'd10};
      8'h7B: if (!ext) lut = {1'b1, 5'd11};
      8'h4E: lut = {1'b1, 5'd11};
      8'h7C: if (!ext) lut = {1'b1, 5'd12};
      8'h4A: lut = {1'b1, 5'd13};
      8'h5A: lut = {1'b1, 5'd14};
      8'h76: lut = {1'b1, 5'd15};
      8'h66: lut = {1'b1, 5'd16};
      default: lut = '0;
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      scan_code  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= par_bad;
      frame_err  <= frm_bad;
      if (par_bad || frm_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk) begin
            scan_code <= shreg;
            if (lut[5]) begin
              key_valid <= 1'b1;
              key_code  <= lut[4:0];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_token_rx.sv
// Directed bench for ps2_key_token_rx: drives PS/2 frames bit by bit and checks tokens, errors and timing.
`timescale 1ns/1ps
module tb_ps2_key_token_rx;
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  ps2_key_token_rx_if bus();
  ps2_key_token_rx dut (.iCLK_50(clk), .iRST_n(rst_n), .bus(bus));

  localparam int H = 15;          // PS/2 half period in system clocks
  localparam int STROBE_K = 11;   // 2 sync + 8 filter stages + 1 edge detect after the line falls

  int checks = 0;
  int errors = 0;
  int vcnt, vpos, pcnt, fcnt, fpos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.iPS2_DAT = b;
    tick(H);
    bus.iPS2_CLK = 1'b0;
    tick(H);
    bus.iPS2_CLK = 1'b1;
  endtask

  // Sends start, data, parity, then the stop bit while recording pulse counts/positions.
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stopv);
    logic [9:0] bits;
    bits = {(~(^b)) ^ pflip, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    bus.iPS2_DAT = stopv;
    tick(H);
    bus.iPS2_CLK = 1'b0;
    vcnt = 0; vpos = 0; pcnt = 0; fcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == H) bus.iPS2_CLK = 1'b1;
      if (bus.oKEY_VALID) begin vcnt++; vpos = k; end
      if (bus.oPARITY_ERR) pcnt++;
      if (bus.oFRAME_ERR) fcnt++;
    end
    bus.iPS2_DAT = 1'b1;
    tick(5);
  endtask

  initial begin
    bus.iPS2_CLK = 1'b1;
    bus.iPS2_DAT = 1'b1;
    rst_n = 1'b0;
    tick(5);
    chk("rst_valid", bus.oKEY_VALID, 0);
    chk("rst_code", bus.oKEY_CODE, 0);
    chk("rst_scan", bus.oSCAN_CODE, 0);
    chk("rst_perr", bus.oPARITY_ERR, 0);
    chk("rst_ferr", bus.oFRAME_ERR, 0);
    rst_n = 1'b1;
    tick(20);

    send_frame(8'h16, 1'b0, 1'b1);
    chk("k16_cnt", vcnt, 1);
    chk("k16_pos", vpos, STROBE_K + 2);
    chk("k16_code", bus.oKEY_CODE, 1);
    chk("k16_scan", bus.oSCAN_CODE, 8'h16);
    chk("k16_errs", pcnt + fcnt, 0);

    send_frame(8'hF0, 1'b0, 1'b1);
    chk("f0_cnt", vcnt, 0);
    send_frame(8'h16, 1'b0, 1'b1);
    chk("brk16_cnt", vcnt, 0);
    chk("brk16_code", bus.oKEY_CODE, 1);
    send_frame(8'h7D, 1'b0, 1'b1);
    chk("k7d_cnt", vcnt, 1);
    chk("k7d_code", bus.oKEY_CODE, 9);

    send_frame(8'hE0, 1'b0, 1'b1);
    chk("e0_cnt", vcnt, 0);
    send_frame(8'h4A, 1'b0, 1'b1);
    chk("e04a_cnt", vcnt, 1);
    chk("e04a_code", bus.oKEY_CODE, 13);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("e075_cnt", vcnt, 0);
    chk("e075_scan", bus.oSCAN_CODE, 8'h75);
    chk("e075_code", bus.oKEY_CODE, 13);

    send_frame(8'h45, 1'b1, 1'b1);
    chk("par_perr", pcnt, 1);
    chk("par_cnt", vcnt, 0);
    chk("par_scan", bus.oSCAN_CODE, 8'h75);
    send_frame(8'h45, 1'b0, 1'b1);
    chk("k45_cnt", vcnt, 1);
    chk("k45_code", bus.oKEY_CODE, 0);

    send_frame(8'h5A, 1'b0, 1'b0);
    chk("stop_ferr", fcnt, 1);
    chk("stop_cnt", vcnt + pcnt, 0);

    // E0 then a truncated frame: the timeout must also drop the E0 flag.
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.iPS2_DAT = 1'b1;
    fcnt = 0; fpos = 0; vcnt = 0;
    for (int k = 1; k <= 50200; k++) begin
      @(posedge clk);
      #1;
      if (bus.oFRAME_ERR) begin fcnt++; fpos = k; end
      if (bus.oKEY_VALID) vcnt++;
    end
    chk("tout_ferr", fcnt, 1);
    chk("tout_pos", (fpos >= 49900 && fpos <= 50100), 1);
    chk("tout_novalid", vcnt, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("tout75_cnt", vcnt, 1);
    chk("tout75_code", bus.oKEY_CODE, 8);
    send_frame(8'h76, 1'b0, 1'b1);
    chk("k76_code", bus.oKEY_CODE, 15);

    // Short low glitch with data low: a real strobe here would misalign the next frame.
    bus.iPS2_DAT = 1'b0;
    tick(5);
    bus.iPS2_CLK = 1'b0;
    tick(3);
    bus.iPS2_CLK = 1'b1;
    tick(20);
    bus.iPS2_DAT = 1'b1;
    tick(5);
    send_frame(8'h66, 1'b0, 1'b1);
    chk("glitch_cnt", vcnt, 1);
    chk("glitch_code", bus.oKEY_CODE, 16);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_code", bus.oKEY_CODE, 0);
    chk("mrst_scan", bus.oSCAN_CODE, 0);
    chk("mrst_valid", bus.oKEY_VALID, 0);
    bus.iPS2_DAT = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'h79, 1'b0, 1'b1);
    chk("k79_cnt", vcnt, 1);
    chk("k79_code", bus.oKEY_CODE, 10);
    chk("k79_scan", bus.oSCAN_CODE, 8'h79);
    send_frame(8'h79, 1'b0, 1'b1);
    chk("k79_rep_cnt", vcnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
